// File: rtl/alu_mc.sv
// alu_mc: single-issue ALU with valid/ready handshakes on the request and result sides.
// Single-cycle ops are registered straight into the output register.
// When ALU_MC_MUL_EN is defined, op 9 (MUL) runs on a shift-add multiplier,
// one partial product per cycle. When the macro is undefined, op 9 is treated
// as an illegal opcode and the multiplier FSM and datapath are not built.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | accepts requests whenever the output register is free
// MUL_BUSY | shift-add multiply in progress; no new requests accepted
// HOLD     | product ready, waiting for the output register to drain
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [WIDTH:0]   asr_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_ill;
  logic [4:0]       alu_flags;

  logic             out_free;
  logic             accept_alu;
  logic             load;
  logic [WIDTH-1:0] load_res;
  logic [4:0]       load_flags;

  assign shamt = b[SHW-1:0];

  // Extended results: the extra bit captures carry/borrow or the last bit shifted out.
  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} - {1'b0, b};
  assign shl_ext = {1'b0, a} << shamt;
  assign shr_ext = {a, 1'b0} >> shamt;
  assign asr_ext = $signed({a, 1'b0}) >>> shamt;

  // Single-cycle datapath; op 9 lands in the default branch and reads as illegal
  // unless the multiplier FSM diverts it first.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (op)
      4'd0: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (add_ext[MSB] != a[MSB]);
      end
      4'd1: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_c   = sub_ext[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (sub_ext[MSB] != a[MSB]);
      end
      4'd2: alu_res = a & b;
      4'd3: alu_res = a | b;
      4'd4: alu_res = a ^ b;
      4'd5: alu_res = ~a;
      4'd6: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      4'd7: begin
        alu_res = shr_ext[WIDTH:1];
        alu_c   = shr_ext[0];
      end
      4'd8: begin
        alu_res = asr_ext[WIDTH:1];
        alu_c   = asr_ext[0];
      end
      default: alu_ill = 1'b1;
    endcase
  end

  assign alu_flags = {alu_ill, alu_v, alu_c, alu_res[MSB], (alu_res == '0)};

  // The output register can take new data if it is empty or being drained this edge.
  assign out_free = !out_valid || out_ready;

`ifdef ALU_MC_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               mul_start;
  logic               mul_done;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     step_sum;
  logic [WIDTH-1:0]   mul_res;
  logic [4:0]         mul_flags;

  // prod_q = {partial high half, remaining multiplier bits}; each step adds the
  // multiplicand when the current multiplier LSB is set, then shifts right.
  assign step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                   + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
  assign mul_res   = prod_q[WIDTH-1:0];
  assign mul_flags = {1'b0, 1'b0, |prod_q[2*WIDTH-1:WIDTH], mul_res[MSB], (mul_res == '0)};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state, request handshake and multiplier control.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    mul_start  = 1'b0;
    mul_done   = 1'b0;
    accept_alu = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = out_free;
        if (in_valid && out_free) begin
          if (op == 4'd9) begin
            mul_start = 1'b1;
            state_d   = MUL_BUSY;
          end else begin
            accept_alu = 1'b1;
          end
        end
      end
      MUL_BUSY: begin
        if (cnt_q == '0) begin
          if (out_free) begin
            mul_done = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          mul_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Multiplier datapath: latch operands on accept, then one shift-add step per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (mul_start) begin
      cnt_q   <= CW'(WIDTH);
      mcand_q <= a;
      prod_q  <= {{WIDTH{1'b0}}, b};
    end else if ((state_q == MUL_BUSY) && (cnt_q != '0)) begin
      cnt_q  <= cnt_q - CW'(1);
      prod_q <= {step_sum, prod_q[WIDTH-1:1]};
    end
  end

  assign load       = accept_alu || mul_done;
  assign load_res   = mul_done ? mul_res : alu_res;
  assign load_flags = mul_done ? mul_flags : alu_flags;
`else
  assign in_ready   = out_free;
  assign accept_alu = in_valid && out_free;
  assign load       = accept_alu;
  assign load_res   = alu_res;
  assign load_flags = alu_flags;
`endif

  // Output register: loads on a completed op, otherwise clears valid once consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= load_res;
      flags     <= load_flags;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: WIDTH=8 and WIDTH=16 instances checked against an
// arithmetic reference model. Honours ALU_MC_MUL_EN the same way as the design.
module tb_alu_mc;

`ifdef ALU_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  a, b, result;
  logic [3:0]  op;
  logic [4:0]  flags;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, result16;
  logic [3:0]  op16;
  logic [4:0]  flags16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  alu_mc #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .flags(flags16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on w-bit values.
  function automatic void model(input int w, input int o, input longint unsigned x,
                                input longint unsigned y, input bit mul_en,
                                output longint unsigned res, output logic [4:0] fl);
    longint unsigned mask, s, p;
    longint          sx, sy, ss, maxs;
    int              sh;
    bit              c, v, ill;
    mask = (64'd1 << w) - 64'd1;
    maxs = longint'((64'd1 << (w - 1)) - 64'd1);
    sh   = int'(y & longint'(w - 1));
    sx   = longint'(x);
    sy   = longint'(y);
    if (((x >> (w - 1)) & 64'd1) != 0) sx = sx - longint'(64'd1 << w);
    if (((y >> (w - 1)) & 64'd1) != 0) sy = sy - longint'(64'd1 << w);
    c = 1'b0; v = 1'b0; ill = 1'b0; res = 0;
    case (o)
      0: begin
        s = x + y; res = s & mask; c = (s > mask);
        ss = sx + sy; v = (ss > maxs) || (ss < -maxs - 1);
      end
      1: begin
        res = (x - y) & mask; c = (x < y);
        ss = sx - sy; v = (ss > maxs) || (ss < -maxs - 1);
      end
      2: res = x & y;
      3: res = x | y;
      4: res = x ^ y;
      5: res = ~x & mask;
      6: begin
        res = (x << sh) & mask;
        c = (sh != 0) && (((x >> (w - sh)) & 64'd1) != 0);
      end
      7: begin
        res = x >> sh;
        c = (sh != 0) && (((x >> (sh - 1)) & 64'd1) != 0);
      end
      8: begin
        res = longint'(sx >>> sh) & mask;
        c = (sh != 0) && (((x >> (sh - 1)) & 64'd1) != 0);
      end
      9: begin
        if (mul_en) begin
          p = x * y; res = p & mask; c = ((p >> w) != 0);
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    fl = {ill, v, c, (((res >> (w - 1)) & 64'd1) != 0), (res == 0)};
  endfunction

  // Issue one request to the 8-bit DUT (out_ready held high) and check the result.
  task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    longint unsigned er;
    logic [4:0]      ef;
    int              lat;
    model(8, int'(o), 64'(x), 64'(y), MUL_EN, er, ef);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("issue_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 4'($urandom);
    lat = 0;
`ifdef ALU_MC_MUL_EN
    if (o == 4'd9) begin
      while (!out_valid && lat < 40) begin
        check("mul_busy_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        lat++;
      end
      check("mul_latency", 64'(lat), 64'd9);
    end
`endif
    check("out_valid", 64'(out_valid), 64'd1);
    check("result", 64'(result), er);
    check("flags", 64'(flags), 64'(ef));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned er, er2;
    logic [4:0]      ef, ef2;
    logic [3:0]      o;
    logic [7:0]      x, y;
    logic [15:0]     x16, y16;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; op16 = '0; out_ready16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_out_valid16", 64'(out_valid16), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_in_ready16", 64'(in_ready16), 64'd1);

    // Directed cases with hand-computed results.
    issue(4'd0, 8'hFF, 8'h01);
    check("add_ff_01_res", 64'(result), 64'h00);
    check("add_ff_01_flags", 64'(flags), 64'(5'b00101));
    issue(4'd1, 8'h80, 8'h01);
    check("sub_80_01_res", 64'(result), 64'h7F);
    check("sub_80_01_flags", 64'(flags), 64'(5'b01000));
    issue(4'd9, 8'h10, 8'h11);
`ifdef ALU_MC_MUL_EN
    check("mul_10_11_res", 64'(result), 64'h10);
    check("mul_10_11_flags", 64'(flags), 64'(5'b00100));
`else
    check("mul_off_res", 64'(result), 64'h00);
    check("mul_off_flags", 64'(flags), 64'(5'b10001));
`endif
    issue(4'd6, 8'h81, 8'h01);
    check("shl_carry_out", 64'(flags), 64'(5'b00100));
    issue(4'd6, 8'hFF, 8'h08);
    check("shl_amount0", 64'(flags), 64'(5'b00010));
    issue(4'd7, 8'h80, 8'h0F);
    issue(4'd8, 8'h80, 8'h07);
    check("asr_fill", 64'(result), 64'hFF);
    issue(4'd5, 8'hFF, 8'h00);
    issue(4'd15, 8'h12, 8'h34);
    check("illegal15", 64'(flags), 64'(5'b10001));

    // WIDTH=16 instance.
    op16 = 4'd8; a16 = 16'h8000; b16 = 16'h000F; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    check("asr16_valid", 64'(out_valid16), 64'd1);
    check("asr16_res", 64'(result16), 64'hFFFF);
    check("asr16_flags", 64'(flags16), 64'(5'b00010));
    op16 = 4'd12; a16 = 16'h1234; b16 = 16'h0005; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    check("ill16_res", 64'(result16), 64'h0000);
    check("ill16_flags", 64'(flags16), 64'(5'b10001));
    for (int i = 0; i < 30; i++) begin
      o = 4'($urandom_range(0, 15));
      if (o == 4'd9) o = 4'd1;
      x16 = 16'($urandom); y16 = 16'($urandom);
      model(16, int'(o), 64'(x16), 64'(y16), MUL_EN, er, ef);
      op16 = o; a16 = x16; b16 = y16; in_valid16 = 1'b1;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      check("rand16_valid", 64'(out_valid16), 64'd1);
      check("rand16_res", 64'(result16), er);
      check("rand16_flags", 64'(flags16), 64'(ef));
    end

    // Random single transactions, MUL included.
    for (int i = 0; i < 60; i++) begin
      issue(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    end

    // Back-to-back single-cycle ops, one per clock.
    o = 4'($urandom_range(0, 8));
    x = 8'($urandom); y = 8'($urandom);
    model(8, int'(o), 64'(x), 64'(y), MUL_EN, er, ef);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      check("b2b_valid", 64'(out_valid), 64'd1);
      check("b2b_res", 64'(result), er);
      check("b2b_flags", 64'(flags), 64'(ef));
      check("b2b_in_ready", 64'(in_ready), 64'd1);
      o = 4'($urandom_range(0, 15));
`ifdef ALU_MC_MUL_EN
      if (o == 4'd9) o = 4'd4;
`endif
      x = 8'($urandom); y = 8'($urandom);
      model(8, int'(o), 64'(x), 64'(y), MUL_EN, er, ef);
      op = o; a = x; b = y;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_last_res", 64'(result), er);
    @(posedge clk); #1;
    check("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: result held for 5 cycles, then consume and accept on the same edge.
    model(8, 0, 64'h37, 64'h4A, MUL_EN, er, ef);
    op = 4'd0; a = 8'h37; b = 8'h4A; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_res", 64'(result), er);
    op = 4'd2;
    for (int i = 0; i < 5; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_res", 64'(result), er);
      check("bp_hold_flags", 64'(flags), 64'(ef));
    end
    model(8, 4, 64'hC3, 64'h5A, MUL_EN, er2, ef2);
    op = 4'd4; a = 8'hC3; b = 8'h5A; out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", 64'(out_valid), 64'd1);
    check("bp_next_res", 64'(result), er2);
    check("bp_next_flags", 64'(flags), 64'(ef2));
    @(posedge clk); #1;

    // Reset pulse three cycles into an op: nothing may be emitted afterwards.
    op = 4'd9; a = 8'h10; b = 8'h11; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rstmid_valid", 64'(out_valid), 64'd0);
    check("rstmid_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("rstmid_no_emit", 64'(out_valid), 64'd0);
    end
    issue(4'd0, 8'd2, 8'd3);
    check("rstmid_add_2_3", 64'(result), 64'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
